// File: rtl/memoram_arb_pkg.sv
// Shared defaults, state encoding and counter sizing for the memoram arbiter.
package memoram_arb_pkg;

  localparam int ADDR_W_DEF       = 6;
  localparam int DATA_W_DEF       = 16;
  localparam int READ_LATENCY_DEF = 2;

  // Width of the read-latency counter; headroom for the capture edge.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 2);
  endfunction

  localparam int CNT_W_DEF = cnt_width(READ_LATENCY_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

endpackage

// File: rtl/memoram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port not granted last wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic winner_o,
  output logic any_o
);

  assign any_o    = req0_i | req1_i;
  // A lone requester wins outright; a tie goes to the port that was not last.
  assign winner_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/memoram_arbiter.sv
// Two-port arbiter and sequencer for the single-port 64x16 memoram with a
// registered two-cycle read path. One request is in flight at a time.
module memoram_arbiter
  import memoram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_q_i
);

  localparam int               CNT_W    = cnt_width(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              busy_q, busy_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              winner;
  logic              any_req;

  rr_pick2 u_pick (
    .req0_i   (req0_i),
    .req1_i   (req1_i),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Next-state, grant and memory-command decode for the IDLE/WRITE/READ sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    last_d    = last_q;
    port_d    = port_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = wren_q;
    rdata_d   = rdata_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        wren_d = 1'b0;
        if (any_req) begin
          port_d  = winner;
          last_d  = winner;
          addr_d  = winner ? addr1_i  : addr0_i;
          data_d  = winner ? wdata1_i : wdata0_i;
          wren_d  = winner ? we1_i    : we0_i;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          cnt_d   = '0;
          state_d = (winner ? we1_i : we0_i) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        // The memory takes the write on this edge; the strobe lasts one cycle.
        wren_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_READ: begin
        // Address held steady while the memory's two-stage read path fills.
        if (cnt_q == CNT_LAST) begin
          rdata_d   = mem_q_i;
          rvalid0_d = ~port_q;
          rvalid1_d = port_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        wren_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      rdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      last_q    <= last_d;
      port_q    <= port_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      rdata_q   <= rdata_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt0_o        = gnt0_q;
  assign gnt1_o        = gnt1_q;
  assign rvalid0_o     = rvalid0_q;
  assign rvalid1_o     = rvalid1_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = busy_q;
  assign mem_address_o = addr_q;
  assign mem_data_o    = data_q;
  assign mem_wren_o    = wren_q;

endmodule
